fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 55 +++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the instruction fetch unit and its buffer.
package fetch_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  // Bits needed to hold a count from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry FIFO of {pc, instr} with synchronous flush; head is visible combinationally.
// A push into a full buffer is only taken when a pop happens in the same cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 41
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        push,
  input  logic [W-1:0]                push_data,
  input  logic                        pop,
  output logic [W-1:0]                head,
  output logic                        valid,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];
  assign valid   = (count != '0);

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with branch redirect, in-order response tracking and a small decode buffer.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets into a sticky FAULT state.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W      = 9,
  parameter int RESET_PC  = 0,
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PcSel,
  input  logic [31:0]        BrPC,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               fetch_fault
);

  localparam int CNT_W = cnt_width(BUF_DEPTH);
  localparam int ENT_W = PC_W + INSTR_W;
  localparam logic [PC_W-1:0] PC_INIT   = PC_W'(RESET_PC);
  localparam logic [CNT_W:0]  DEPTH_LIM = (CNT_W + 1)'(BUF_DEPTH);

  fetch_state_e     state;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  rsp_pc;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] out_next;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W:0]   in_flight;
  logic [ENT_W-1:0] head;
  logic             redirect;
  logic             misalign;
  logic             req_fire;
  logic             rsp_seen;
  logic             push;
  logic             pop;
  logic             buf_valid;
  logic             unused_brpc;

  assign redirect    = PcSel && (state != FAULT);
  assign redirect_pc = {BrPC[PC_W-1:2], 2'b00};
  assign unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

  // Slots are reserved at request time, so the buffer can always absorb every response.
  assign in_flight      = {1'b0, outstanding} + {1'b0, occupancy};
  assign imem_req_valid = (state == RUN) && !PcSel && (in_flight < DEPTH_LIM);
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_seen = imem_rsp_valid && (outstanding != '0);
  assign out_next = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_seen);
  assign push     = rsp_seen && (state == RUN) && !PcSel && (drop == '0);
  assign pop      = buf_valid && if_ready;

  // rsp_pc is the address of the next response that will be kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= PC_INIT;
      rsp_pc      <= PC_INIT;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect)
        drop <= out_next;
      else if (rsp_seen && (drop != '0))
        drop <= drop - CNT_W'(1);

      case (state)
        IDLE: begin
          state <= RUN;
          if (redirect) begin
            pc     <= redirect_pc;
            rsp_pc <= redirect_pc;
          end
        end
        RUN: begin
          if (misalign) begin
            state <= FAULT;
          end else if (redirect) begin
            pc     <= redirect_pc;
            rsp_pc <= redirect_pc;
          end else begin
            if (req_fire) pc <= pc + PC_W'(4);
            if (push)     rsp_pc <= rsp_pc + PC_W'(4);
          end
        end
        FAULT:   state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault;

  assign misalign = redirect && (state == RUN) && (BrPC[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         fault <= 1'b0;
    else if (misalign) fault <= 1'b1;
  end

  assign fetch_fault = fault;
`else
  assign misalign    = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .W     (ENT_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (pop),
    .head      (head),
    .valid     (buf_valid),
    .count     (occupancy)
  );

  assign if_valid = buf_valid;
  assign if_pc    = buf_valid ? head[ENT_W-1:INSTR_W] : '0;
  assign if_instr = buf_valid ? head[INSTR_W-1:0] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a memory model answers requests in order, and the
// decode stream is compared against the ideal program-order stream restarted at each redirect target.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int PC_W      = 9;
  localparam int BUF_DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            PcSel = 1'b0;
  logic [31:0]     BrPC = 32'h0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [31:0]     imem_rsp_data = 32'h0;
  logic            if_valid;
  logic            if_ready = 1'b0;
  logic [31:0]     if_instr;
  logic [PC_W-1:0] if_pc;
  logic            fetch_fault;

  fetch_unit #(.PC_W(PC_W), .RESET_PC(0), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .PcSel          (PcSel),
    .BrPC           (BrPC),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [PC_W-1:0] pc; logic [31:0] instr; } exp_t;
  typedef struct packed { logic [PC_W-1:0] addr; logic [31:0] due; } mreq_t;

  exp_t            exp_q[$];
  mreq_t           memq[$];
  int              checks = 0;
  int              passed = 0;
  int              cyc = 0;
  int              fires = 0;
  int              pops = 0;
  int              lat_min = 1;
  int              lat_max = 1;
  bit              rr_rand = 0;
  bit              ir_rand = 0;
  bit              rr_fix = 1;
  bit              ir_fix = 1;
  bit              fault_mode = 0;
  logic [PC_W-1:0] exp_next = '0;
  logic [PC_W-1:0] req_pc = '0;
  logic [PC_W-1:0] last_addr = '0;

  function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
    return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [PC_W-1:0] target(input logic [31:0] b);
    logic [PC_W-1:0] t;
    t = b[PC_W-1:0];
    t[1:0] = 2'b00;
    return t;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] r;
    r = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
    r[1:0] = 2'b00;
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: exp_next, instr: mem_word(exp_next)});
      exp_next = exp_next + PC_W'(4);
    end
  endtask

  // One clock cycle of stimulus: memory response, handshake inputs, optional redirect.
  task automatic step(input bit sel, input logic [31:0] br);
    @(negedge clk);
    cyc++;
    if (memq.size() != 0 && memq[0].due <= 32'(cyc)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fix;
    if_ready       = sel ? 1'b0 : (ir_rand ? 1'($urandom_range(0, 1)) : ir_fix);
    PcSel = sel;
    BrPC  = br;
    if (sel) begin
      exp_q.delete();
      exp_next = target(br);
      req_pc   = target(br);
`ifdef FETCH_MISALIGN_CHECK_EN
      if (br[1:0] != 2'b00) fault_mode = 1;
`endif
    end
    refill();
    #1;
    if (sel) chk("req_blocked_on_redirect", 32'(imem_req_valid), 32'h0);
    if (imem_req_valid && imem_req_ready) begin
      fires++;
      last_addr = imem_addr;
      if (fault_mode) begin
        checks++;
        $display("FAIL req_in_fault: got request %h expected none", imem_addr);
      end
      chk("imem_addr", 32'(imem_addr), 32'(req_pc));
      req_pc = req_pc + PC_W'(4);
      memq.push_back('{addr: imem_addr, due: 32'(cyc) + 32'($urandom_range(lat_min, lat_max))});
    end
  endtask

  // Monitor: pops the scoreboard on every decode handshake and checks hold-while-stalled.
  bit   held = 0;
  exp_t held_v;
  exp_t e;
  always @(negedge clk) begin
    #2;
    if (reset) begin
      held = 0;
    end else begin
      if (held) begin
        chk("hold_valid", 32'(if_valid), 32'h1);
        chk("hold_pc", 32'(if_pc), 32'(held_v.pc));
        chk("hold_instr", if_instr, held_v.instr);
      end
      held   = if_valid && !if_ready && !PcSel;
      held_v = '{pc: if_pc, instr: if_instr};
      if (if_valid && if_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL sb_empty: got pc %h with no expected entry", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("if_pc", 32'(if_pc), 32'(e.pc));
          chk("if_instr", if_instr, e.instr);
        end
      end
    end
  end

  int f0, p0, k;

  initial begin
    #12;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", 32'(if_pc), 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Decode stalled: only BUF_DEPTH requests may go out.
    ir_fix = 0; rr_fix = 1;
    f0 = fires;
    repeat (10) step(0, 32'h0);
    chk("stall_req_count", 32'(fires - f0), 32'(BUF_DEPTH));
    chk("stall_req_valid", 32'(imem_req_valid), 32'h0);

    // Free-flowing 1-cycle memory.
    ir_fix = 1;
    p0 = pops;
    repeat (30) step(0, 32'h0);
    chk("flow_progress", 32'(pops - p0 >= 10), 32'h1);

    // Redirect with two requests in flight.
    lat_min = 3; lat_max = 3;
    k = 0;
    while (memq.size() < 2 && k < 20) begin step(0, 32'h0); k++; end
    chk("drop_setup_outstanding", 32'(memq.size()), 32'h2);
    step(1, 32'h40);
    p0 = pops;
    repeat (15) step(0, 32'h0);
    chk("drop_progress", 32'(pops > p0), 32'h1);

    // Wrap through 0x1FC -> 0x000.
    lat_min = 1; lat_max = 1;
    step(1, 32'h1F8);
    p0 = pops;
    repeat (12) step(0, 32'h0);
    chk("wrap_progress", 32'(pops - p0 >= 3), 32'h1);

    // Random traffic with occasional redirects.
    rr_rand = 1; ir_rand = 1; lat_min = 1; lat_max = 4;
    p0 = pops;
    repeat (1500) step($urandom_range(0, 39) == 0, rand_target());
    chk("random_progress", 32'(pops - p0 > 100), 32'h1);

    // Misaligned redirect target.
    rr_rand = 0; ir_rand = 0; rr_fix = 1; ir_fix = 1; lat_min = 1; lat_max = 1;
    step(1, 32'h42);
`ifdef FETCH_MISALIGN_CHECK_EN
    f0 = fires;
    repeat (10) step(0, 32'h0);
    chk("fault_flag", 32'(fetch_fault), 32'h1);
    chk("fault_no_req", 32'(fires - f0), 32'h0);
    chk("fault_if_valid", 32'(if_valid), 32'h0);
`else
    f0 = fires;
    k = 0;
    while (fires == f0 && k < 10) begin step(0, 32'h0); k++; end
    chk("misalign_req_seen", 32'(fires > f0), 32'h1);
    chk("misalign_req_addr", 32'(last_addr), 32'h40);
    chk("misalign_fault_tied", 32'(fetch_fault), 32'h0);
`endif

    // Reset in the middle of a burst.
    lat_min = 2; lat_max = 2;
    repeat (6) step(0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("midrst_if_valid", 32'(if_valid), 32'h0);
    chk("midrst_if_instr", if_instr, 32'h0);
    chk("midrst_if_pc", 32'(if_pc), 32'h0);
    chk("midrst_fault", 32'(fetch_fault), 32'h0);
    memq.delete();
    exp_q.delete();
    exp_next = '0;
    req_pc = '0;
    fault_mode = 0;
    imem_rsp_valid = 1'b0;
    repeat (2) step(0, 32'h0);
    reset = 1'b0;
    lat_min = 1; lat_max = 1;
    f0 = fires;
    p0 = pops;
    k = 0;
    while (fires == f0 && k < 10) begin step(0, 32'h0); k++; end
    chk("restart_req_seen", 32'(fires > f0), 32'h1);
    chk("restart_addr", 32'(last_addr), 32'h0);
    repeat (20) step(0, 32'h0);
    chk("restart_progress", 32'(pops - p0 >= 5), 32'h1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
